fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write-side arbiter that shares one synchronous FWFT FIFO (`fifo_sync_top`) between `NUM_REQ` producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr_en`/`data_in` from the granted producer, honouring back-pressure from `full`. It sits directly in front of the FIFO write port; the read side is untouched.

## Interface
- `NUM_REQ`, 4, number of producers (≥2)
- `DATA_WIDTH`, 8, data width; matches the FIFO
- `BURST_LEN`, 4, maximum beats per grant (≥1)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  NUM_REQ  per-producer valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  flattened; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  per-producer ready; one-hot or zero
- `fifo_full`  in  1  FIFO `full`
- `fifo_wr_en`  out  1  FIFO `wr_en`
- `fifo_data`  out  DATA_WIDTH  FIFO `data_in`
- `grant_id`  out  $clog2(NUM_REQ)  index of the current/last granted producer
- `busy`  out  1  high while in GRANT

## Operation
- FSM, two states: IDLE, GRANT.
- IDLE:
  - If any `req_valid` is high, select the first valid index searching upward from `rr_ptr`, wrapping NUM_REQ-1→0.
  - Register the winner into `grant_id` and go to GRANT. No transfer happens in IDLE.
- GRANT, with g = `grant_id`:
  - `req_ready[g] = !fifo_full`; all other ready bits are 0.
  - Transfer when `req_valid[g] && req_ready[g]`. On a transfer: `fifo_wr_en=1`, `fifo_data=req_data[g]`, and `beat_cnt` increments.
- Release, GRANT→IDLE, happens on either of:
  - a transfer that brings `beat_cnt` to `BURST_LEN`;
  - `req_valid[g]` low in any GRANT cycle, regardless of `fifo_full`.
- On release: `rr_ptr <= (g+1) mod NUM_REQ`, `beat_cnt <= 0`.
- FIFO full: ready is held low and the grant is held indefinitely while valid stays high. There is no timeout.
- `fifo_data` equals `req_data[grant_id]` whenever in GRANT, and 0 in IDLE.
- Widths:
  - `beat_cnt` is $clog2(BURST_LEN+1) bits.
  - `rr_ptr` and `grant_id` are $clog2(NUM_REQ) bits; increment wraps modulo NUM_REQ (not power-of-two wrap when NUM_REQ is not a power of two).
- Reset (synchronous, any cycle, including mid-burst):
  - state IDLE; `rr_ptr=0`, `grant_id=0`, `beat_cnt=0`.
  - The in-flight burst is abandoned; no `fifo_wr_en` in the reset cycle.

## Timing
- Outputs immediately after reset: `req_ready=0`, `fifo_wr_en=0`, `fifo_data=0`, `grant_id=0`, `busy=0`.
- `req_ready`, `fifo_wr_en`, `fifo_data` are combinational from registered state, `req_valid[g]` and `fifo_full`. There is no combinational path from `req_data` into any control output.
- Arbitration latency: valid seen in IDLE at cycle N → grant registered at edge N+1 → first transfer possible in cycle N+1.
- One idle bubble per grant, then up to BURST_LEN back-to-back transfers.
- Full burst without back-pressure: BURST_LEN+1 cycles per grant.
- A transfer in the same cycle the FIFO deasserts `full` is allowed. A simultaneous FIFO read in that cycle is the FIFO's concern.

## Structure
- Shared package `fifo_pkg`:
  - `arb_state_t` enum {IDLE, GRANT};
  - a function `rr_next(ptr, n)` for modulo increment.
- One sub-module: `fifo_rr_pick`. It is combinational: inputs `req_valid` and `rr_ptr`; outputs `found` and winner index, with rotate-then-priority-encode.
- Top level holds the FSM, `rr_ptr`, `beat_cnt`, `grant_id`, and the output mux.

## Test plan
- Reset then single requester: `req_valid=4'b0100` with data 0xA0..0xA5 streaming → grant_id=2 at the cycle after valid. Writes 0xA0–0xA3 on 4 consecutive cycles, one bubble, regrant 2, then 0xA4, 0xA5.
- All four valid continuously from reset → grant order 0,1,2,3,0. Each grant writes exactly 4 beats; fifo_wr_en duty is 4 of every 5 cycles.
- Back-pressure: fifo_full=1 for 3 cycles mid-burst (after beat 2) → req_ready and fifo_wr_en low for those 3 cycles. Grant is held and the burst resumes with beats 3–4; no data is lost or duplicated.
- Early release: producer 1 drops valid after 2 beats while producer 3 is valid → release. rr_ptr=2, the next grant goes to 3, and producer 1's beat count restarts at 0 on its next grant.
- Wrap and non-power-of-two: NUM_REQ=3, only producers 2 and 0 valid, rr_ptr=2 → grants alternate 2,0,2. rr_ptr never reaches 3.
- Reset mid-burst: assert rst after beat 1 of grant 1 → no fifo_wr_en that cycle and all outputs 0 next cycle. The first post-reset grant goes to the lowest valid index from 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// Holds the arbiter state encoding and the modulo pointer increment.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Wraps at n rather than at the next power of two.
    function automatic int unsigned rr_next(
        input int unsigned ptr,
        input int unsigned n
    );
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin winner selection: rotate the valid vector so rr_ptr sits at
// bit 0, priority-encode the lowest set bit, then un-rotate the index.
module fifo_rr_pick
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic               found,
    output logic [IW-1:0]      winner
);

    logic [NUM_REQ-1:0] rot;
    int                 idx;
    int                 sel;

    always_comb begin
        rot   = '0;
        found = 1'b0;
        sel   = 0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            rot[i] = req_valid[idx];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                sel   = i;
            end
        end
        idx = int'(rr_ptr) + sel;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        winner = IW'(idx);
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-side arbiter sharing one FWFT FIFO between producers.
// One idle bubble per grant, then up to BURST_LEN beats to the FIFO.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_LEN  = 4,
    localparam int IW         = $clog2(NUM_REQ),
    localparam int BW         = $clog2(BURST_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic          found;
    logic [IW-1:0] winner;
    logic          in_grant;
    logic          g_valid;
    logic          xfer;
    logic [BW-1:0] beat_inc;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .found     (found),
        .winner    (winner)
    );

    assign in_grant = (state_q == GRANT);
    assign g_valid  = req_valid[grant_id_q];
    // Gated by rst so an abandoned burst never writes in the reset cycle.
    assign xfer     = in_grant && g_valid && !fifo_full && !rst;
    assign beat_inc = beat_cnt_q + BW'(1);

    always_comb begin
        req_ready = '0;
        if (in_grant && !fifo_full && !rst) req_ready[grant_id_q] = 1'b1;
    end

    assign fifo_wr_en = xfer;
    assign fifo_data  = in_grant
                      ? req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH]
                      : '0;
    assign grant_id   = grant_id_q;
    assign busy       = in_grant;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!g_valid || (xfer && beat_inc == BW'(BURST_LEN))) begin
                    state_d    = IDLE;
                    rr_ptr_d   = IW'(rr_next(32'(grant_id_q), NUM_REQ));
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: a 4-producer instance for the main
// scenarios and a 3-producer instance for non-power-of-two wrap.
module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data;
    logic [1:0]  grant_id;
    logic        busy;

    logic [2:0]  req_valid3;
    logic [23:0] req_data3;
    logic [2:0]  req_ready3;
    logic        fifo_full3;
    logic        fifo_wr_en3;
    logic [7:0]  fifo_data3;
    logic [1:0]  grant_id3;
    logic        busy3;

    logic [7:0]  base [4];
    logic [7:0]  cnt [4];
    logic [7:0]  base3 [3];
    logic [7:0]  cnt3 [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = base[i] + cnt[i];
        for (int i = 0; i < 3; i++) req_data3[i*8 +: 8] = base3[i] + cnt3[i];
    end

    fifo_wr_arb #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    fifo_wr_arb #(.NUM_REQ(3), .DATA_WIDTH(8), .BURST_LEN(4)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid3),
        .req_data   (req_data3),
        .req_ready  (req_ready3),
        .fifo_full  (fifo_full3),
        .fifo_wr_en (fifo_wr_en3),
        .fifo_data  (fifo_data3),
        .grant_id   (grant_id3),
        .busy       (busy3)
    );

    // Producers advance their data on every accepted handshake.
    task automatic step();
        logic [3:0] hs;
        logic [2:0] hs3;
        hs  = req_ready & req_valid;
        hs3 = req_ready3 & req_valid3;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (hs[i]) cnt[i] = cnt[i] + 8'd1;
        for (int i = 0; i < 3; i++) if (hs3[i]) cnt3[i] = cnt3[i] + 8'd1;
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        fifo_full  = 1'b0;
        fifo_full3 = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = '0;
        for (int i = 0; i < 3; i++) cnt3[i] = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b exp 0000", req_ready);
        end
        checks++;
        if (fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_en got %b exp 0", fifo_wr_en);
        end
        checks++;
        if (fifo_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h exp 00", fifo_data);
        end
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_grant got %0d exp 0", grant_id);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        step();
    endtask

    task automatic test_single();
        int eb [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        int ew [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        int eg [10] = '{0, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        int ed [10] = '{'h00, 'hA0, 'hA1, 'hA2, 'hA3,
                        'h00, 'hA4, 'hA5, 'hA6, 'h00};
        logic [11:0] obs, exp;
        do_reset();
        base[2] = 8'hA0;
        for (int c = 0; c < 10; c++) begin
            req_valid = (cnt[2] < 8'd6) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            obs = {busy, fifo_wr_en, grant_id, fifo_data};
            exp = {1'(eb[c]), 1'(ew[c]), 2'(eg[c]), 8'(ed[c])};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single cyc %0d got %h exp %h", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_all_four();
        int          exp_cnt [4] = '{0, 0, 0, 0};
        int          ph, gi, writes;
        logic [11:0] obs, exp;
        do_reset();
        for (int i = 0; i < 4; i++) base[i] = 8'(i * 16);
        writes = 0;
        for (int c = 0; c < 25; c++) begin
            req_valid = 4'b1111;
            @(negedge clk);
            ph = c % 5;
            gi = (c / 5) % 4;
            if (ph == 0) begin
                exp = {1'b0, 1'b0,
                       2'((c == 0) ? 0 : ((c / 5) + 3) % 4), 8'h00};
            end else begin
                exp = {1'b1, 1'b1, 2'(gi), 8'(gi * 16 + exp_cnt[gi])};
                exp_cnt[gi]++;
            end
            obs = {busy, fifo_wr_en, grant_id, fifo_data};
            if (fifo_wr_en === 1'b1) writes++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL all_four cyc %0d got %h exp %h", c, obs, exp);
            end
            step();
        end
        checks++;
        if (writes != 20) begin
            errors++;
            $display("FAIL all_four_duty got %0d exp 20", writes);
        end
    endtask

    task automatic test_backpressure();
        int ef [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        int eb [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        int ew [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        int ed [9] = '{'h00, 'hB0, 'hB1, 'hB2, 'hB2,
                       'hB2, 'hB2, 'hB3, 'h00};
        logic [15:0] obs, exp;
        do_reset();
        base[0] = 8'hB0;
        for (int c = 0; c < 9; c++) begin
            req_valid = (cnt[0] < 8'd4) ? 4'b0001 : 4'b0000;
            fifo_full = 1'(ef[c]);
            @(negedge clk);
            obs = {req_ready, busy, fifo_wr_en, grant_id, fifo_data};
            exp = {(eb[c] == 1 && ef[c] == 0) ? 4'b0001 : 4'b0000,
                   1'(eb[c]), 1'(ew[c]), 2'd0, 8'(ed[c])};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL backpressure cyc %0d got %h exp %h", c, obs, exp);
            end
            step();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_early_release();
        int eb [15] = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int ew [15] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int eg [15] = '{0, 1, 1, 1, 1, 3, 3, 3, 3, 3, 1, 1, 1, 1, 1};
        int ed [15] = '{'h00, 'h10, 'h11, 'h12, 'h00,
                        'h30, 'h31, 'h32, 'h33, 'h00,
                        'h12, 'h13, 'h14, 'h15, 'h00};
        logic [15:0] obs, exp;
        do_reset();
        base[1] = 8'h10;
        base[3] = 8'h30;
        for (int c = 0; c < 15; c++) begin
            req_valid = {1'b1, 1'b0, (c != 3), 1'b0};
            @(negedge clk);
            obs = {req_ready, busy, fifo_wr_en, grant_id, fifo_data};
            exp = {(eb[c] == 1) ? 4'(1 << eg[c]) : 4'b0000,
                   1'(eb[c]), 1'(ew[c]), 2'(eg[c]), 8'(ed[c])};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL early_release cyc %0d got %h exp %h", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_wrap_np2();
        int eb [14] = '{0, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        int ew [14] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        int eg [14] = '{0, 1, 1, 2, 2, 2, 2, 2, 0, 0, 0, 0, 0, 2};
        int ed [14] = '{'h00, 'h10, 'h00, 'h20, 'h21, 'h22, 'h23,
                        'h00, 'h00, 'h01, 'h02, 'h03, 'h00, 'h24};
        logic [14:0] obs, exp;
        do_reset();
        for (int i = 0; i < 3; i++) base3[i] = 8'(i * 16);
        for (int c = 0; c < 14; c++) begin
            req_valid3 = (c == 0) ? 3'b010 : 3'b101;
            @(negedge clk);
            obs = {req_ready3, busy3, fifo_wr_en3, grant_id3, fifo_data3};
            exp = {(eb[c] == 1) ? 3'(1 << eg[c]) : 3'b000,
                   1'(eb[c]), 1'(ew[c]), 2'(eg[c]), 8'(ed[c])};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wrap_np2 cyc %0d got %h exp %h", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        int er [7] = '{0, 0, 0, 0, 1, 0, 0};
        int ev [7] = '{1, 2, 2, 2, 2, 11, 11};
        int eb [7] = '{0, 1, 0, 1, 0, 0, 1};
        int ew [7] = '{0, 0, 0, 1, 0, 0, 1};
        int eg [7] = '{0, 0, 0, 1, 0, 0, 0};
        int ed [7] = '{'h00, 'h50, 'h00, 'h60, 'h00, 'h00, 'h50};
        logic [15:0] obs, exp;
        do_reset();
        base[0] = 8'h50;
        base[1] = 8'h60;
        for (int c = 0; c < 7; c++) begin
            rst       = 1'(er[c]);
            req_valid = 4'(ev[c]);
            @(negedge clk);
            if (er[c] == 1) begin
                obs = {req_ready, 12'h000, fifo_wr_en, 3'b000};
                exp = 16'h0000;
            end else begin
                obs = {req_ready, busy, fifo_wr_en, grant_id, fifo_data};
                exp = {(eb[c] == 1) ? 4'(1 << eg[c]) : 4'b0000,
                       1'(eb[c]), 1'(ew[c]), 2'(eg[c]), 8'(ed[c])};
            end
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid cyc %0d got %h exp %h", c, obs, exp);
            end
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) base[i] = '0;
        for (int i = 0; i < 3; i++) base3[i] = '0;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_early_release();
        test_wrap_np2();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
